// File: rtl/fft_sink_framer.sv
// fft_sink_framer: turns a continuous sample stream into framed Avalon-ST
// packets for the FFT core sink. The transform length and direction are
// chosen per frame, the core may apply backpressure, and frames may run
// back to back with no gap cycle between eop and the next sop.
module fft_sink_framer #(
    parameter int DATA_W    = 14,
    parameter int MAX_LOG2  = 10,
    parameter int MIN_LOG2  = 3,
    parameter int REAL_ONLY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [MAX_LOG2:0]   pts_cfg,
    input  logic                inverse_cfg,
    input  logic [DATA_W-1:0]   in_real,
    input  logic [DATA_W-1:0]   in_imag,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                sink_ready,
    output logic                sink_valid,
    output logic                sink_sop,
    output logic                sink_eop,
    output logic [1:0]          sink_error,
    output logic [DATA_W-1:0]   outreal,
    output logic [DATA_W-1:0]   outimag,
    output logic                inverse,
    output logic [MAX_LOG2:0]   fft_pts,
    output logic                busy,
    output logic                cfg_err,
    output logic [15:0]         frame_cnt
);

    localparam int PTS_W = MAX_LOG2 + 1;
    localparam int IDX_W = MAX_LOG2;
    localparam logic [PTS_W-1:0] MAX_PTS = PTS_W'(1) << MAX_LOG2;
    localparam logic [PTS_W-1:0] MIN_PTS = PTS_W'(1) << MIN_LOG2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             cfg_ok;
    logic             is_last;
    logic             accept;
    logic [PTS_W-1:0] last_idx;

    // A single set bit within the port width is already at most 2^MAX_LOG2,
    // so only the lower bound needs an explicit comparison.
    always_comb begin
        cfg_ok   = (pts_cfg != '0)
                   && ((pts_cfg & (pts_cfg - PTS_W'(1))) == '0)
                   && (pts_cfg >= MIN_PTS);
        last_idx = fft_pts - PTS_W'(1);
        is_last  = ({1'b0, idx} == last_idx);
    end

    // The output register is a one-stage pipeline: a new sample may enter
    // whenever the register is empty or is being drained this cycle.
    assign in_ready   = (state == RUN) && (!sink_valid || sink_ready);
    assign accept     = in_valid && in_ready;
    assign busy       = (state == RUN);
    assign sink_error = {1'b0, cfg_err};

    // Framing state machine together with the registered sink-side word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            sink_valid <= 1'b0;
            sink_sop   <= 1'b0;
            sink_eop   <= 1'b0;
            outreal    <= '0;
            outimag    <= '0;
            inverse    <= 1'b0;
            fft_pts    <= MAX_PTS;
            cfg_err    <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            if (accept) begin
                outreal    <= in_real;
                outimag    <= (REAL_ONLY != 0) ? '0 : in_imag;
                sink_valid <= 1'b1;
                sink_sop   <= (idx == '0);
                sink_eop   <= is_last;
            end else if (sink_valid && sink_ready) begin
                sink_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        if (cfg_ok) begin
                            fft_pts <= pts_cfg;
                            inverse <= inverse_cfg;
                            idx     <= '0;
                            state   <= RUN;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (is_last) begin
                            idx       <= '0;
                            frame_cnt <= frame_cnt + 16'd1;
                            if (enable && cfg_ok) begin
                                fft_pts <= pts_cfg;
                                inverse <= inverse_cfg;
                            end else begin
                                state <= IDLE;
                                if (enable) begin
                                    cfg_err <= 1'b1;
                                end
                            end
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_sink_framer.sv
// tb_fft_sink_framer: a scoreboard fed by an independent frame model checks
// every word leaving the sink port; a configuration table and hand-written
// sequences cover reset, backpressure, frame boundaries and config errors.
module tb_fft_sink_framer;

    localparam int DATA_W = 14;
    localparam int PTS_W  = 11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic [PTS_W-1:0]  pts_cfg = 11'd1024;
    logic              inverse_cfg = 1'b0;
    logic [DATA_W-1:0] in_real = '0;
    logic [DATA_W-1:0] in_imag = '0;
    logic              in_valid = 1'b0;
    logic              sink_ready = 1'b1;

    logic              in_ready, sink_valid, sink_sop, sink_eop, inverse, busy, cfg_err;
    logic [1:0]        sink_error;
    logic [DATA_W-1:0] outreal, outimag;
    logic [PTS_W-1:0]  fft_pts;
    logic [15:0]       frame_cnt;

    logic              r1_in_ready, r1_valid, r1_sop, r1_eop, r1_inverse, r1_busy, r1_cfg_err;
    logic [1:0]        r1_error;
    logic [DATA_W-1:0] r1_real, r1_imag;
    logic [PTS_W-1:0]  r1_pts;
    logic [15:0]       r1_frame_cnt;

    fft_sink_framer #(.DATA_W(DATA_W), .MAX_LOG2(10), .MIN_LOG2(3), .REAL_ONLY(0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .pts_cfg(pts_cfg), .inverse_cfg(inverse_cfg),
        .in_real(in_real), .in_imag(in_imag), .in_valid(in_valid), .in_ready(in_ready),
        .sink_ready(sink_ready), .sink_valid(sink_valid), .sink_sop(sink_sop),
        .sink_eop(sink_eop), .sink_error(sink_error), .outreal(outreal), .outimag(outimag),
        .inverse(inverse), .fft_pts(fft_pts), .busy(busy), .cfg_err(cfg_err),
        .frame_cnt(frame_cnt)
    );

    fft_sink_framer #(.DATA_W(DATA_W), .MAX_LOG2(10), .MIN_LOG2(3), .REAL_ONLY(1)) dut_real (
        .clk(clk), .rst(rst), .enable(enable), .pts_cfg(pts_cfg), .inverse_cfg(inverse_cfg),
        .in_real(in_real), .in_imag(in_imag), .in_valid(in_valid), .in_ready(r1_in_ready),
        .sink_ready(sink_ready), .sink_valid(r1_valid), .sink_sop(r1_sop),
        .sink_eop(r1_eop), .sink_error(r1_error), .outreal(r1_real), .outimag(r1_imag),
        .inverse(r1_inverse), .fft_pts(r1_pts), .busy(r1_busy), .cfg_err(r1_cfg_err),
        .frame_cnt(r1_frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
        logic              sop;
        logic              eop;
        logic [PTS_W-1:0]  pts;
        logic              inv;
    } word_t;

    typedef struct {
        logic [PTS_W-1:0] pts;
        logic             inv;
        logic             exp_busy;
        logic             exp_err;
        logic [PTS_W-1:0] exp_pts;
        logic             exp_inv;
    } cfg_vec_t;

    word_t    exp_q[$];
    cfg_vec_t cfg_vec[10];

    int   tests = 0;
    int   fails = 0;
    int   acc_count = 0;
    int   m_idx = 0;
    int   m_pts = 1024;
    int   m_frames = 0;
    logic m_inv = 1'b0;
    int   ready_mode = 0;
    logic stall_prev = 1'b0;
    logic [2*DATA_W+2:0] stall_word = '0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: fresh random samples, ready per current mode.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        sink_ready = (ready_mode == 0) ? 1'b1 : ~sink_ready;
        in_real    = DATA_W'($urandom);
        in_imag    = DATA_W'($urandom);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus();
    endtask

    task automatic runAccepts(input int n);
        int target;
        int budget;
        target = acc_count + n;
        budget = n * 4 + 100;
        while (acc_count < target && budget > 0) begin
            applyStimulus();
            budget--;
        end
        if (acc_count < target) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: got %0d accepts expected %0d", acc_count, target);
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        m_idx      = 0;
        m_frames   = 0;
        stall_prev = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic startRun(input int pts, input logic inv);
        pts_cfg     = PTS_W'(pts);
        inverse_cfg = inv;
        m_pts       = pts;
        m_inv       = inv;
        m_idx       = 0;
        enable      = 1'b1;
        in_valid    = 1'b1;
    endtask

    // Monitor on the falling edge: model each accept, score each transfer.
    always @(negedge clk) begin
        word_t w;
        if (!rst) begin
            if (stall_prev) begin
                checkOutput("hold_while_stalled",
                            64'({outreal, outimag, sink_sop, sink_eop, sink_valid}),
                            64'(stall_word));
            end
            stall_prev = sink_valid && !sink_ready;
            stall_word = {outreal, outimag, sink_sop, sink_eop, sink_valid};

            if (sink_valid) begin
                checkOutput("real_only_copy", 64'({r1_valid, r1_imag, r1_real}),
                            64'({1'b1, {DATA_W{1'b0}}, outreal}));
            end

            if (sink_valid && sink_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_word: got real %0h with empty scoreboard", outreal);
                end else begin
                    w = exp_q.pop_front();
                    checkOutput("word", 64'({outreal, outimag, sink_sop, sink_eop}),
                                64'({w.re, w.im, w.sop, w.eop}));
                    if (w.sop) begin
                        checkOutput("frame_cfg", 64'({fft_pts, inverse}), 64'({w.pts, w.inv}));
                    end
                end
            end

            if (in_valid && in_ready) begin
                w.re  = in_real;
                w.im  = in_imag;
                w.sop = (m_idx == 0);
                w.eop = (m_idx == m_pts - 1);
                w.pts = PTS_W'(m_pts);
                w.inv = m_inv;
                exp_q.push_back(w);
                acc_count++;
                if (w.eop) begin
                    m_idx = 0;
                    m_frames++;
                    m_pts = int'(pts_cfg);
                    m_inv = inverse_cfg;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cfg_vec[0] = '{11'd8,    1'b0, 1'b1, 1'b0, 11'd8,    1'b0};
        cfg_vec[1] = '{11'd16,   1'b1, 1'b1, 1'b0, 11'd16,   1'b1};
        cfg_vec[2] = '{11'd1024, 1'b0, 1'b1, 1'b0, 11'd1024, 1'b0};
        cfg_vec[3] = '{11'd512,  1'b1, 1'b1, 1'b0, 11'd512,  1'b1};
        cfg_vec[4] = '{11'd4,    1'b0, 1'b0, 1'b1, 11'd1024, 1'b0};
        cfg_vec[5] = '{11'd100,  1'b1, 1'b0, 1'b1, 11'd1024, 1'b0};
        cfg_vec[6] = '{11'd0,    1'b1, 1'b0, 1'b1, 11'd1024, 1'b0};
        cfg_vec[7] = '{11'd1023, 1'b0, 1'b0, 1'b1, 11'd1024, 1'b0};
        cfg_vec[8] = '{11'd2047, 1'b0, 1'b0, 1'b1, 11'd1024, 1'b0};
        cfg_vec[9] = '{11'd1536, 1'b1, 1'b0, 1'b1, 11'd1024, 1'b0};

        // Reset state
        doReset();
        @(negedge clk);
        checkOutput("reset_flags", 64'({sink_valid, sink_sop, sink_eop, busy, cfg_err, in_ready, inverse}), 64'd0);
        checkOutput("reset_pts", 64'(fft_pts), 64'd1024);
        checkOutput("reset_frame_cnt", 64'(frame_cnt), 64'd0);
        checkOutput("reset_data", 64'({outreal, outimag, sink_error}), 64'd0);

        // Configuration validation table
        for (int i = 0; i < 10; i++) begin
            doReset();
            pts_cfg     = cfg_vec[i].pts;
            inverse_cfg = cfg_vec[i].inv;
            in_valid    = 1'b0;
            enable      = 1'b1;
            idleCycles(3);
            @(negedge clk);
            checkOutput("cfg_busy", 64'({busy, in_ready}), 64'({cfg_vec[i].exp_busy, cfg_vec[i].exp_busy}));
            checkOutput("cfg_err", 64'({cfg_err, sink_error}), 64'({cfg_vec[i].exp_err, 1'b0, cfg_vec[i].exp_err}));
            checkOutput("cfg_latch", 64'({fft_pts, inverse}), 64'({cfg_vec[i].exp_pts, cfg_vec[i].exp_inv}));
        end

        // 1024-point frames, no backpressure, back to back
        doReset();
        ready_mode = 0;
        startRun(1024, 1'b0);
        runAccepts(1024);
        @(negedge clk);
        checkOutput("frame_cnt_1024", 64'(frame_cnt), 64'd1);
        checkOutput("pts_1024", 64'(fft_pts), 64'd1024);
        runAccepts(4);

        // 16-point IFFT frames under toggling backpressure, then enable drop mid-frame
        doReset();
        ready_mode = 1;
        startRun(16, 1'b1);
        runAccepts(48);
        @(negedge clk);
        checkOutput("frame_cnt_16", 64'(frame_cnt), 64'd3);
        checkOutput("inverse_16", 64'(inverse), 64'd1);
        runAccepts(5);
        enable = 1'b0;
        runAccepts(11);
        idleCycles(6);
        @(negedge clk);
        checkOutput("drain_idle", 64'({busy, sink_valid}), 64'd0);
        checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
        checkOutput("drain_frame_cnt", 64'(frame_cnt), 64'd4);

        // Mid-frame length change only takes effect at the boundary
        doReset();
        ready_mode = 0;
        startRun(64, 1'b0);
        runAccepts(20);
        pts_cfg = 11'd256;
        runAccepts(44);
        @(negedge clk);
        checkOutput("switch_pts", 64'(fft_pts), 64'd256);
        checkOutput("switch_frame_cnt", 64'(frame_cnt), 64'd1);
        runAccepts(250);
        enable = 1'b0;
        runAccepts(6);
        idleCycles(4);
        @(negedge clk);
        checkOutput("switch_frame_cnt2", 64'(frame_cnt), 64'd2);
        checkOutput("switch_idle", 64'(busy), 64'd0);

        // Invalid length: stays idle with sticky error until reset
        doReset();
        pts_cfg  = 11'd100;
        enable   = 1'b1;
        in_valid = 1'b1;
        idleCycles(4);
        @(negedge clk);
        checkOutput("bad_cfg_err", 64'({cfg_err, sink_error}), 64'({1'b1, 2'b01}));
        checkOutput("bad_cfg_idle", 64'({in_ready, busy, sink_valid}), 64'd0);
        doReset();
        startRun(128, 1'b0);
        idleCycles(1);
        @(negedge clk);
        checkOutput("recover_err", 64'({cfg_err, sink_error}), 64'd0);
        runAccepts(131);
        @(negedge clk);
        checkOutput("recover_frame_cnt", 64'(frame_cnt), 64'd1);
        checkOutput("recover_busy", 64'(busy), 64'd1);

        // Reset in the middle of a 1024-point frame, then a clean restart
        doReset();
        startRun(1024, 1'b0);
        runAccepts(500);
        doReset();
        @(negedge clk);
        checkOutput("midreset_flags", 64'({sink_valid, sink_sop, sink_eop, busy}), 64'd0);
        checkOutput("midreset_frame_cnt", 64'(frame_cnt), 64'd0);
        startRun(8, 1'b0);
        runAccepts(20);
        enable = 1'b0;
        runAccepts(4);
        idleCycles(4);
        @(negedge clk);
        checkOutput("restart_frame_cnt", 64'(frame_cnt), 64'd3);
        checkOutput("restart_idle", 64'({busy, sink_valid}), 64'd0);
        checkOutput("final_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
